// File: rtl/writeback_arbiter_if.sv
// Two-lane writeback request bus plus the register-file write port and
// hazard/occupancy status driven back by the arbiter.
interface writeback_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NREG  = 2 ** REG_AW;

    logic              iswb0;
    logic              isld0;
    logic [15:0]       instr0;
    logic [DATA_W-1:0] ldresult0;
    logic [DATA_W-1:0] aluresult0;
    logic              iswb1;
    logic              isld1;
    logic [15:0]       instr1;
    logic [DATA_W-1:0] ldresult1;
    logic [DATA_W-1:0] aluresult1;

    logic              stall;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   pending;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  iswb0, isld0, instr0, ldresult0, aluresult0,
        input  iswb1, isld1, instr1, ldresult1, aluresult1,
        output stall, rf_we, rf_waddr, rf_wdata, pending, count
    );

    modport master (
        output iswb0, isld0, instr0, ldresult0, aluresult0,
        output iswb1, isld1, instr1, ldresult1, aluresult1,
        input  stall, rf_we, rf_waddr, rf_wdata, pending, count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// In-order writeback queue: accepts up to two lane results per cycle and
// drains one register-file write per cycle, exporting a pending-register mask.
module writeback_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    writeback_arbiter_if.slave wb
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 2 ** REG_AW;

    logic [CW-1:0]     count_reg, count_next;
    logic [PW-1:0]     wptr_reg, wptr_next;
    logic [PW-1:0]     rptr_reg, rptr_next;
    logic [PW-1:0]     slot1;
    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [REG_AW-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NREG-1:0]   entry_mask [DEPTH];

    logic              we_reg;
    logic [REG_AW-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              stall, wr0, wr1, deq;
    logic [REG_AW-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic [NREG-1:0]   pending;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Leaving two free slots guarantees a dual accept can always land.
    assign stall = count_reg > CW'(DEPTH - 2);
    assign addr0 = wb.instr0[8 +: REG_AW];
    assign addr1 = wb.instr1[8 +: REG_AW];
    assign data0 = wb.isld0 ? wb.ldresult0 : wb.aluresult0;
    assign data1 = wb.isld1 ? wb.ldresult1 : wb.aluresult1;

    // Same-destination pair: the younger lane1 write supersedes lane0.
    assign wr1 = !stall && wb.iswb1;
    assign wr0 = !stall && wb.iswb0 && !(wb.iswb1 && (addr0 == addr1));
    assign deq = (count_reg != '0);

    always_comb begin
        slot1      = wr0 ? ptr_inc(wptr_reg) : wptr_reg;
        wptr_next  = wr1 ? ptr_inc(slot1) : (wr0 ? ptr_inc(wptr_reg) : wptr_reg);
        rptr_next  = deq ? ptr_inc(rptr_reg) : rptr_reg;
        count_next = count_reg + CW'(wr0) + CW'(wr1) - CW'(deq);
        valid_next = valid_reg;
        if (deq) begin
            valid_next[rptr_reg] = 1'b0;
        end
        if (wr0) begin
            valid_next[wptr_reg] = 1'b1;
        end
        if (wr1) begin
            valid_next[slot1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            valid_reg <= '0;
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            count_reg <= count_next;
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            valid_reg <= valid_next;
            we_reg    <= deq;
            if (deq) begin
                waddr_reg <= addr_mem[rptr_reg];
                wdata_reg <= data_mem[rptr_reg];
            end
        end
    end

    // Storage carries no reset; validity is tracked separately in valid_reg.
    always_ff @(posedge clk) begin
        if (wr0) begin
            addr_mem[wptr_reg] <= addr0;
            data_mem[wptr_reg] <= data0;
        end
        if (wr1) begin
            addr_mem[slot1] <= addr1;
            data_mem[slot1] <= data1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign entry_mask[gi] = valid_reg[gi] ? (NREG'(1) << addr_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pending = we_reg ? (NREG'(1) << waddr_reg) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | entry_mask[i];
        end
    end

    assign wb.stall    = stall;
    assign wb.rf_we    = we_reg;
    assign wb.rf_waddr = waddr_reg;
    assign wb.rf_wdata = wdata_reg;
    assign wb.pending  = pending;
    assign wb.count    = count_reg;
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sequences register-file writes from the two issue lanes onto the single register-file write port.
- Each cycle it accepts up to two writeback requests, lane0 then lane1 in program order, into an in-order queue.
- It drains one write per cycle, stalls upstream when the queue lacks room, and exports a pending-destination mask for hazard checks.
- Sits between the load/ALU result stage and the register file.

Parameters:
DEPTH, 4, queue entries; legal values ≥2.
DATA_W, 16, result width.
REG_AW, 3, destination register index width (8 registers).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
iswb0  input  1  lane0 (older) requests writeback
isld0  input  1  lane0 result comes from load; else from ALU
instr0  input  16  lane0 instruction; destination is instr0[10:8]
ldresult0  input  DATA_W  lane0 load data
aluresult0  input  DATA_W  lane0 ALU result
iswb1  input  1  lane1 (younger) requests writeback
isld1  input  1  lane1 load select
instr1  input  16  lane1 instruction; destination is instr1[10:8]
ldresult1  input  DATA_W  lane1 load data
aluresult1  input  DATA_W  lane1 ALU result
stall  output  1  upstream must hold; lane inputs ignored while high
rf_we  output  1  register-file write enable, registered
rf_waddr  output  REG_AW  write address, registered
rf_wdata  output  DATA_W  write data, registered
pending  output  8  bit r set while any write to register r is queued or on the port
count  output  $clog2(DEPTH+1)  occupied queue entries

Behaviour:
- Reset (rst high at an edge): queue flushed; count=0; rf_we=0; rf_waddr=0; rf_wdata=0; pending=0; stall=0. Queued writes are discarded, including a reset mid-drain. Inputs in the reset cycle are ignored.
- Data select at enqueue: data = isld ? ldresult : aluresult; addr = instr[10:8]. Only {addr, data} is stored.
- stall is combinational from count: stall = (count > DEPTH-2). It does not depend on same-cycle iswb.
- Enqueue, when stall=0:
  - Lane0 is written first, then lane1.
  - Both valid: two entries in the order lane0, lane1.
  - One valid: one entry.
- Same-cycle same-destination coalescing: iswb0 && iswb1 && instr0[10:8]==instr1[10:8] enqueues only the lane1 entry (younger wins). Lane0's write is dropped.
- Dequeue:
  - Each edge with count>0 (pre-update), the head is popped into rf_we/rf_waddr/rf_wdata with rf_we=1.
  - When count=0, rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Latency: a request accepted at edge N into an empty queue drives rf_we at edge N+1. The register file commits at edge N+2.
  - Second entry of a dual accept reaches the port at edge N+2.
- Simultaneous enqueue and dequeue in one cycle are both permitted: count_next = count + enq_n − deq.
  - Enqueue never overflows because of the stall threshold.
  - Dequeue never reads an entry enqueued in the same cycle.
- Queue is circular; pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
- pending = OR of one-hot(addr) over all valid queue entries, OR one-hot(rf_waddr) when rf_we=1. It is combinational from registered state.
- No forwarding of queued data. Consumers use pending to stall reads.

Test Plan:
1. Reset, then lane0 only: iswb0=1, isld0=0, instr0[10:8]=3, aluresult0=16'h1234 at edge 0 -> edge 1: rf_we=1, rf_waddr=3, rf_wdata=16'h1234, pending=8'h08; edge 2: rf_we=0, pending=0.
2. Dual, different destinations: lane0 ld r1=16'hAAAA, lane1 alu r2=16'h5555 -> rf writes r1 then r2 on consecutive cycles; count 2→1→0.
3. Coalesce: both lanes target r5, lane0=16'h0001, lane1=16'h0002 -> single write r5=16'h0002; count peaks at 1.
4. Backpressure: DEPTH=4, dual requests every cycle -> stall=1 once count reaches 3. No requests are lost, and writes appear in exact program order across pointer wrap (16 entries total).
5. isld mux: isld1=1, ldresult1=16'hBEEF, aluresult1=16'hDEAD -> rf_wdata=16'hBEEF.
6. Reset mid-drain with 3 queued entries -> next edge: count=0, rf_we=0, pending=0, stall=0, and no further writes appear.
